// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution window controller.
package conv_pkg;

    // Frame-level controller state, also exported on the debug port.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } conv_state_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel stream, line-buffer feed and window-coordinate bundle.
//
// Handshake: a transfer happens on a rising edge where s_valid && s_ready
// are both high. The source holds s_valid/s_data stable until accepted;
// s_ready may drop at any time (it follows out_ready while running).
// lb_valid/lb_din mirror exactly the accepted transfers with zero latency.
// win_valid is a one-cycle qualifier for win_row/win_col, which hold their
// last value while win_valid is low.
interface conv_window_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_LENGTH = 32,
    parameter int NUM_ROWS   = 32
);
    import conv_pkg::*;

    localparam int RW = cnt_width(NUM_ROWS);
    localparam int CW = cnt_width(ROW_LENGTH);

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  lb_valid;
    logic [DATA_WIDTH-1:0] lb_din;
    logic                  out_ready;
    logic                  win_valid;
    logic [RW-1:0]         win_row;
    logic [CW-1:0]         win_col;

    // Source / parent side: drives pixels and downstream readiness.
    modport master (
        output s_valid, s_data, out_ready,
        input  s_ready, lb_valid, lb_din, win_valid, win_row, win_col
    );

    // Controller side.
    modport slave (
        input  s_valid, s_data, out_ready,
        output s_ready, lb_valid, lb_din, win_valid, win_row, win_col
    );

endinterface

// File: rtl/wrap_counter.sv
// Modulo counter with enable and synchronous clear; o_wrap flags the
// enabled step from MODULUS-1 back to 0.
module wrap_counter #(
    parameter int MODULUS = 4,
    parameter int WIDTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_last;

    assign w_last  = (r_count == LAST);
    assign o_count = r_count;
    assign o_wrap  = i_en && w_last;

    // Count enabled steps, folding back to zero after the terminal value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame controller for a KxK convolution window fed from a line buffer.
// It gates the pixel stream into the line buffer, tracks the pixel
// coordinate, and flags when the buffer holds a window lying fully
// inside the image.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROW_LENGTH  = 32,
    parameter int NUM_ROWS    = 32,
    parameter int KERNEL_SIZE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output conv_state_t o_dbg_state,
    conv_window_ctrl_if.slave bus
);

    localparam int RW = cnt_width(NUM_ROWS);
    localparam int CW = cnt_width(ROW_LENGTH);

    // Offset from the newest pixel back to the window's top-left corner.
    localparam logic [RW-1:0] ROW_OFF = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] COL_OFF = CW'(KERNEL_SIZE - 1);

    conv_state_t     r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_win_valid;
    logic [RW-1:0]   r_win_row;
    logic [CW-1:0]   r_win_col;

    logic                  w_accept;
    logic                  w_clr;
    logic                  w_col_wrap;
    logic                  w_row_wrap;
    logic                  w_win_hit;
    logic [RW-1:0]         w_row;
    logic [CW-1:0]         w_col;
    logic [DATA_WIDTH-1:0] w_din;

    // Stream gating: ready only while running and downstream can take a window.
    assign bus.s_ready  = (r_state == S_RUN) && bus.out_ready;
    assign w_accept     = bus.s_valid && bus.s_ready;
    assign w_din        = bus.s_data;
    assign bus.lb_valid = w_accept;
    assign bus.lb_din   = w_din;

    // Counters sit at zero outside RUN so every frame starts at (0,0).
    assign w_clr = abort || (r_state != S_RUN);

    wrap_counter #(.MODULUS(ROW_LENGTH), .WIDTH(CW)) u_col (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_accept),
        .i_clr   (w_clr),
        .o_count (w_col),
        .o_wrap  (w_col_wrap)
    );

    wrap_counter #(.MODULUS(NUM_ROWS), .WIDTH(RW)) u_row (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_col_wrap),
        .i_clr   (w_clr),
        .o_count (w_row),
        .o_wrap  (w_row_wrap)
    );

    // A window is complete only when both coordinates have passed K-1;
    // the column test also rejects windows that straddle a row boundary.
    // The row counter wraps exactly on the frame's final pixel.
    assign w_win_hit = w_accept && (w_row >= ROW_OFF) && (w_col >= COL_OFF);

    // Frame FSM with registered busy/done; abort wins over everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_row_wrap) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Window qualifier and top-left coordinate, one cycle after the pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            r_win_valid <= w_win_hit && !abort;
            if (w_win_hit && !abort) begin
                r_win_row <= w_row - ROW_OFF;
                r_win_col <= w_col - COL_OFF;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign o_dbg_state   = r_state;
    assign bus.win_valid = r_win_valid;
    assign bus.win_row   = r_win_row;
    assign bus.win_col   = r_win_col;

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter ROW_LENGTH, default 32, pixels per image row.
REQ-003 Parameter NUM_ROWS, default 32, rows per image frame.
REQ-004 Parameter KERNEL_SIZE, default 3, square window edge; SHALL satisfy 1 <= KERNEL_SIZE <= min(ROW_LENGTH, NUM_ROWS).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin one frame; accepted only in IDLE.
REQ-008 abort  input  1  synchronous frame cancel, any state.
REQ-009 s_valid  input  1  source pixel valid.
REQ-010 s_data  input  DATA_WIDTH  source pixel.
REQ-011 s_ready  output  1  controller accepts pixel this cycle.
REQ-012 lb_valid  output  1  drives line-buffer valid_in; high exactly on accepted pixels.
REQ-013 lb_din  output  DATA_WIDTH  drives line-buffer din; equals s_data of accepted pixel.
REQ-014 out_ready  input  1  downstream MAC/consumer can take a window.
REQ-015 win_valid  output  1  line-buffer window is fully inside the image.
REQ-016 win_row, win_col  output  clog2(NUM_ROWS), clog2(ROW_LENGTH)  top-left coordinate of valid window.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  one-cycle pulse at frame completion.

Function
REQ-019 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on acceptance of pixel (NUM_ROWS-1, ROW_LENGTH-1); DONE->IDLE after exactly one cycle.
REQ-020 abort SHALL force IDLE next cycle from any state, clear counters, suppress done; abort beats start when both high.
REQ-021 start in RUN or DONE SHALL be ignored.
REQ-022 s_ready = (state==RUN) && out_ready, combinational; accept = s_valid && s_ready.
REQ-023 lb_valid = accept and lb_din = s_data, combinational (zero latency into line buffer).
REQ-024 Column counter col increments per accept, wraps ROW_LENGTH-1 -> 0 and then increments row counter; both counters are 0 on entering RUN.
REQ-025 win_valid SHALL be registered: high in cycle after an accept of pixel (r,c) with r >= KERNEL_SIZE-1 and c >= KERNEL_SIZE-1, else low.
REQ-026 On win_valid, win_row = r-(KERNEL_SIZE-1), win_col = c-(KERNEL_SIZE-1); outputs hold last value when win_valid low.
REQ-027 Windows straddling a row boundary (c < KERNEL_SIZE-1) SHALL never raise win_valid.
REQ-028 Total win_valid pulses per frame = (NUM_ROWS-KERNEL_SIZE+1)*(ROW_LENGTH-KERNEL_SIZE+1).
REQ-029 done SHALL be high in the DONE state cycle, coincident with the final win_valid.
REQ-030 s_valid low or out_ready low in RUN stalls counters and FSM without loss; no pixel accepted twice.

Reset
REQ-031 On rst low: state IDLE, counters 0, win_valid 0, win_row/win_col 0, done 0, busy 0; s_ready and lb_valid therefore 0.
REQ-032 Reset mid-frame discards the frame; no done pulse follows reset release.

Structure
REQ-033 Shared package conv_pkg holds the FSM state enum and counter-width localparams/functions.
REQ-034 One sub-module natural: wrap_counter (parameterised modulus, enable, clear, wrap flag), instanced for col and row.
REQ-035 Line buffer is instanced by the parent, not inside this block.

Verification
REQ-036 ROW_LENGTH=4, NUM_ROWS=4, K=3, continuous s_valid/out_ready -> 16 accepts, 4 win_valid at (0,0),(0,1),(1,0),(1,1), done coincident with 4th.
REQ-037 Same config, s_valid toggling every other cycle -> identical window sequence, busy throughout, no duplicated lb_valid.
REQ-038 out_ready low for 5 cycles mid-row -> s_ready low, counters frozen, sequence resumes unchanged.
REQ-039 abort after 7 accepts -> IDLE next cycle, no done; subsequent start yields full correct frame.
REQ-040 rst pulsed at accept 10 -> all outputs 0 asynchronously, no done; start with ignored-while-RUN second start produces exactly one frame.
